rect_pos_arbiter: RTL
=====================

Name: rect_pos_arbiter

Overview:
- Shares the rectangle-position input of the draw_rect datapath between two requesters: channel 0 (mouse/control path) and channel 1 (autonomous animation or keyboard path).
- Decides once per frame, at the rising edge of vertical blanking, which requester owns the position.
- Latches and clamps the chosen coordinates, then acknowledges the winner with a one-cycle grant.
- Sits between the position sources and draw_rect, in the pclk domain.

Parameters:
- H_ACTIVE, 800, visible width in pixels.
- V_ACTIVE, 600, visible height in pixels.
- RECT_W, 48, rectangle width, used for clamping.
- RECT_H, 64, rectangle height, used for clamping.
- HOLD_FRAMES, 4, number of consecutive frames an owner keeps priority while it is still requesting (range 1..15).

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- vblnk  in  1  vertical blanking level from the timing generator.
- req0  in  1  channel 0 requests a position update.
- xpos0  in  12  channel 0 x coordinate.
- ypos0  in  12  channel 0 y coordinate.
- req1  in  1  channel 1 requests a position update.
- xpos1  in  12  channel 1 x coordinate.
- ypos1  in  12  channel 1 y coordinate.
- gnt0  out  1  one-cycle pulse: channel 0 coordinates consumed.
- gnt1  out  1  one-cycle pulse: channel 1 coordinates consumed.
- xpos  out  12  registered rectangle x position to draw_rect.
- ypos  out  12  registered rectangle y position to draw_rect.
- upd  out  1  one-cycle pulse: xpos/ypos changed this frame.
- owner  out  2  current owner: 0 = none, 1 = channel 0, 2 = channel 1.

Behaviour:
- Reset:
  - xpos, ypos, gnt0, gnt1, upd, owner = 0.
  - State = IDLE, hold counter = 0, round-robin pointer = channel 0.
  - vblnk_d = 1, so no spurious tick if vblnk is high when reset releases.
- Frame tick: tick = vblnk & ~vblnk_d in cycle t. All arbitration results register at the end of cycle t and are visible in cycle t+1. Latency from the vblnk rise to the outputs is 1 cycle.
- Requests and data are sampled only in the tick cycle. Requests or coordinate changes outside the tick cycle are ignored.
- gnt0, gnt1 and upd are high for exactly one cycle (t+1), otherwise 0.
- A requester must hold req and its coordinates steady through the tick cycle. It may drop req after seeing gnt.
- State machine (evaluated only on tick):
  - IDLE:
    - req0 only → OWN0.
    - req1 only → OWN1.
    - Both → the channel indicated by the round-robin pointer.
    - Neither → stay IDLE, no grant, no upd.
  - OWN0 (likewise OWN1):
    - Owner requesting and hold counter < HOLD_FRAMES-1 → grant owner, hold counter +1.
    - Owner requesting, hold counter expired and the other channel requesting → switch to the other channel, hold counter = 0.
    - Owner requesting, hold counter expired, other channel idle → keep owner, hold counter saturates.
    - Owner not requesting, other channel requesting → switch, hold counter = 0.
    - Neither requesting → IDLE, hold counter = 0.
  - On entry to IDLE the round-robin pointer moves to the channel that did not own last.
  - Entering OWNx grants channel x in the same tick.
- Clamp rules:
  - xpos = min(x_sel, H_ACTIVE-RECT_W).
  - ypos = min(y_sel, V_ACTIVE-RECT_H).
  - Compares are unsigned 12-bit; values above 4095 are impossible.
- upd = 1 whenever a grant issues, even if the new coordinates equal the old ones.
- owner reflects the state after the tick: IDLE = 0, OWN0 = 1, OWN1 = 2.
- Reset mid-frame: outputs return to reset values on the next edge. The first tick occurs only after vblnk has been seen low and then high.

Optional Feature:
- Macro RECT_ARB_FIXED_PRIO_EN.
- Defined: channel 0 always wins when requesting; HOLD_FRAMES and the round-robin pointer are ignored. Channel 1 is granted only on ticks where req0 = 0.
- Undefined: the hold/round-robin policy above.

Decomposition:
- Shared package rect_arb_pkg holds:
  - state encoding for IDLE/OWN0/OWN1;
  - owner codes;
  - coordinate width 12;
  - default screen constants 800/600.
- One natural sub-module: vblnk_edge_det (registered rising-edge detector with reset-high history).
- Arbitration FSM, hold counter and clamp stay in the top module.

Test Plan:
- Reset released with vblnk=1, req0=1 → no gnt/upd until vblnk goes 0 then 1. At the first rise: gnt0=1 in cycle t+1, xpos/ypos = xpos0/ypos0 (100,200), owner=1.
- req0 and req1 both held, HOLD_FRAMES=4 → grants over frames are 0,0,0,0,1,1,1,1,0…; gnt and upd are each exactly one cycle wide.
- req1 only, xpos1=790, ypos1=590 → xpos=752, ypos=536, gnt1 pulse, owner=2.
- req pulsed between ticks only → no grant, outputs unchanged, owner returns to 0 on the next tick.
- rst asserted for one cycle while in OWN1 → next cycle all outputs 0, owner=0. Arbitration then restarts from IDLE with the pointer at channel 0.
- RECT_ARB_FIXED_PRIO_EN defined, both requesting for 10 frames → gnt0 every frame, gnt1 never. After req0 drops, gnt1 on the next tick.

Source files
------------

// File: rtl/rect_arb_pkg.sv
// Shared types and constants for the rectangle-position arbiter.
// Optional RECT_ARB_FIXED_PRIO_EN (used by rect_pos_arbiter) selects fixed channel-0 priority.
package rect_arb_pkg;

    localparam int unsigned COORD_W      = 12;
    localparam int unsigned HOLD_W       = 4;
    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_V_ACTIVE = 600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CH0  = 2'd1;
    localparam logic [1:0] OWNER_CH1  = 2'd2;

    // Saturate a coordinate so the rectangle stays on screen.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [1:0] owner_code(input arb_state_e s);
        case (s)
            ST_OWN0: return OWNER_CH0;
            ST_OWN1: return OWNER_CH1;
            default: return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vblnk_edge_det.sv
// Rising-edge detector on vblnk; history resets high so a vblnk already
// high at reset release does not produce a tick.
module vblnk_edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk,
    output logic tick_c
);

    logic vblnk_d_q;
    logic vblnk_d_d;

    always_comb begin
        vblnk_d_d = vblnk;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_d_q <= 1'b1;
        end else begin
            vblnk_d_q <= vblnk_d_d;
        end
    end

    assign tick_c = vblnk & ~vblnk_d_q;

endmodule

// File: rtl/rect_pos_arbiter.sv
// Per-frame arbiter sharing the draw_rect position between two requesters.
// Define RECT_ARB_FIXED_PRIO_EN for fixed channel-0 priority instead of hold/round-robin.
module rect_pos_arbiter
    import rect_arb_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned RECT_W      = 48,
    parameter int unsigned RECT_H      = 64,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vblnk,
    input  logic               req0,
    input  logic [COORD_W-1:0] xpos0,
    input  logic [COORD_W-1:0] ypos0,
    input  logic               req1,
    input  logic [COORD_W-1:0] xpos1,
    input  logic [COORD_W-1:0] ypos1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               upd,
    output logic [1:0]         owner
);

    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_ACTIVE - RECT_W);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - RECT_H);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    logic tick_c;

    arb_state_e         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               rr_q, rr_d;      // 0 = channel 0 preferred, 1 = channel 1
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               upd_q, upd_d;
    logic [COORD_W-1:0] xpos_q, xpos_d;
    logic [COORD_W-1:0] ypos_q, ypos_d;
    logic [1:0]         owner_q, owner_d;

    vblnk_edge_det u_edge (
        .pclk   (pclk),
        .rst    (rst),
        .vblnk  (vblnk),
        .tick_c (tick_c)
    );

    // Next-state, hold/pointer update and registered outputs; only ticks change anything.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        upd_d   = 1'b0;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        owner_d = owner_q;

        if (tick_c) begin
`ifdef RECT_ARB_FIXED_PRIO_EN
            hold_d = '0;
            if (req0) begin
                state_d = ST_OWN0;
            end else if (req1) begin
                state_d = ST_OWN1;
            end else begin
                state_d = ST_IDLE;
            end
`else
            case (state_q)
                ST_IDLE: begin
                    hold_d = '0;
                    if (req0 && (!req1 || !rr_q)) begin
                        state_d = ST_OWN0;
                    end else if (req1) begin
                        state_d = ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if (req0 && (hold_q < HOLD_LAST)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end else if (req1) begin
                        state_d = ST_OWN1;
                        hold_d  = '0;
                    end else if (!req0) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                        rr_d    = 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (req1 && (hold_q < HOLD_LAST)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end else if (req0) begin
                        state_d = ST_OWN0;
                        hold_d  = '0;
                    end else if (!req1) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                        rr_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
`endif
            // Every tick that lands in an owned state consumes that owner's coordinates.
            if (state_d == ST_OWN0) begin
                gnt0_d = 1'b1;
                upd_d  = 1'b1;
                xpos_d = clamp_coord(xpos0, X_MAX);
                ypos_d = clamp_coord(ypos0, Y_MAX);
            end else if (state_d == ST_OWN1) begin
                gnt1_d = 1'b1;
                upd_d  = 1'b1;
                xpos_d = clamp_coord(xpos1, X_MAX);
                ypos_d = clamp_coord(ypos1, Y_MAX);
            end
            owner_d = owner_code(state_d);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            upd_q   <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            owner_q <= OWNER_NONE;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            upd_q   <= upd_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            owner_q <= owner_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign upd   = upd_q;
    assign xpos  = xpos_q;
    assign ypos  = ypos_q;
    assign owner = owner_q;

endmodule
